adsr_env: RTL

ADSR_ENV -- requirements
Module: adsr_env

---
 rtl/adsr_env_if.sv | 25 ++
 rtl/adsr_env.sv | 139 +++++++++++++
 2 files changed

// File: rtl/adsr_env_if.sv
// adsr_env_if: envelope control inputs and envelope/stage outputs of adsr_env.
// master drives the note gate, step clock and rates; slave is the envelope generator.
interface adsr_env_if #(
    parameter int W = 8
) ();
    logic         clk_adsr;
    logic         gate;
    logic [W-1:0] attack;
    logic [W-1:0] decay;
    logic [W-1:0] sustain;
    logic [W-1:0] release_rate;
    logic [W-1:0] env;
    logic [2:0]   stage;
    logic         active;

    modport master (
        output clk_adsr, gate, attack, decay, sustain, release_rate,
        input  env, stage, active
    );

    modport slave (
        input  clk_adsr, gate, attack, decay, sustain, release_rate,
        output env, stage, active
    );
endinterface

// File: rtl/adsr_env.sv
// adsr_env: ADSR envelope generator stepped by a synchronized tick, gated by a synchronized note gate.
// Define ADSR_EXP_EN for exponential DECAY/RELEASE slope (step = rate + env/8); default is linear.
//
// state   | meaning
// IDLE    | no note, env held at 0
// ATTACK  | env rises by attack each tick until full scale
// DECAY   | env falls each tick until it reaches the sustain level
// SUSTAIN | env follows the sustain input every clk while gate stays high
// RELEASE | env falls each tick until 0, then back to IDLE
module adsr_env #(
    parameter int W = 8
) (
    input logic       clk,
    input logic       arst_n,
    adsr_env_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [W:0] FULL = {1'b0, {W{1'b1}}};

    state_t       stage;
    logic [W-1:0] env;
    logic         active;

    // [0],[1] synchronize, [2] holds the previous synchronized level
    logic [2:0] ck_sr;
    logic [2:0] gt_sr;
    logic       tick;
    logic       rise;
    logic       fall;

    logic [W:0] env_w;
    logic [W:0] sus_w;
    logic [W:0] sum_att;
    logic [W:0] dec_gap;
    logic [W:0] step_dec;
    logic [W:0] step_rel;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ck_sr <= '0;
            gt_sr <= '0;
        end else begin
            ck_sr <= {ck_sr[1:0], bus.clk_adsr};
            gt_sr <= {gt_sr[1:0], bus.gate};
        end
    end

    assign tick = ck_sr[1] & ~ck_sr[2];
    assign rise = gt_sr[1] & ~gt_sr[2];
    assign fall = ~gt_sr[1] & gt_sr[2];

    // All arithmetic one bit wider than env so sums and steps never wrap.
    always_comb begin
        env_w   = {1'b0, env};
        sus_w   = {1'b0, bus.sustain};
        sum_att = env_w + {1'b0, bus.attack};
        dec_gap = env_w - sus_w;
`ifdef ADSR_EXP_EN
        step_dec = {1'b0, bus.decay} + (env_w >> 3);
        step_rel = {1'b0, bus.release_rate} + (env_w >> 3);
`else
        step_dec = {1'b0, bus.decay};
        step_rel = {1'b0, bus.release_rate};
`endif
    end

    // Gate events win over a coincident tick; that tick is simply lost.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stage  <= IDLE;
            env    <= '0;
            active <= 1'b0;
        end else if (rise) begin
            stage  <= ATTACK;
            active <= 1'b1;
        end else if (fall) begin
            if (stage == ATTACK || stage == DECAY || stage == SUSTAIN) begin
                stage  <= RELEASE;
                active <= 1'b1;
            end
        end else begin
            case (stage)
                IDLE: begin
                    env <= '0;
                end
                ATTACK: begin
                    if (tick && bus.attack != '0) begin
                        if (sum_att >= FULL) begin
                            env   <= FULL[W-1:0];
                            stage <= DECAY;
                        end else begin
                            env <= sum_att[W-1:0];
                        end
                    end
                end
                DECAY: begin
                    if (tick) begin
                        if (env_w <= sus_w || (step_dec != '0 && step_dec >= dec_gap)) begin
                            env   <= bus.sustain;
                            stage <= SUSTAIN;
                        end else if (step_dec != '0) begin
                            env <= env - step_dec[W-1:0];
                        end
                    end
                end
                SUSTAIN: begin
                    env <= bus.sustain;
                end
                RELEASE: begin
                    if (tick && step_rel != '0) begin
                        if (step_rel >= env_w) begin
                            env    <= '0;
                            stage  <= IDLE;
                            active <= 1'b0;
                        end else begin
                            env <= env - step_rel[W-1:0];
                        end
                    end
                end
                default: begin
                    stage  <= IDLE;
                    env    <= '0;
                    active <= 1'b0;
                end
            endcase
        end
    end

    assign bus.env    = env;
    assign bus.stage  = stage;
    assign bus.active = active;
endmodule
